// File: rtl/dbus_wishbone_if.sv
// dbus_wishbone_if
// ----------------
// Data-side bus interface between the MEM stage and the external data memory.
// It turns the single-cycle RAM request from MEM (ce/we/sel/addr/data) into a
// classic Wishbone master cycle. It holds the pipeline via stallreq_o until the
// slave acknowledges, and returns load data to MEM. A watchdog counter aborts
// any cycle that goes TIMEOUT BUSY cycles without an acknowledge.
//
// Parameters
//   TIMEOUT     : BUSY cycles allowed without wb_ack_i before abort (1..255)
//
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   cpu_ce_i    : MEM request valid
//   cpu_we_i    : 1 = store, 0 = load
//   cpu_addr_i  : byte address
//   cpu_sel_i   : byte lanes, bit 3 = bits 31:24
//   cpu_data_i  : store data
//   cpu_data_o  : load data back to MEM (combinational)
//   stall_i     : pipeline stall vector, bit 0 = PC .. bit 5 = WB
//   flush_i     : exception flush
//   stallreq_o  : stall request to ctrl (combinational)
//   bus_err_o   : one-cycle pulse when a cycle is aborted by the watchdog
//   wb_*_o      : registered Wishbone master outputs
//   wb_dat_i    : slave read data
//   wb_ack_i    : slave acknowledge
module dbus_wishbone_if #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        bus_err_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic [31:0] rd_buf;
  logic        timeout_hit;
  logic        is_load;
  logic        stall_any;

  // wb_we_o is still valid for the whole BUSY phase, so it tells us whether
  // the access in flight is a load without keeping a separate flag.
  assign is_load     = ~wb_we_o;
  assign timeout_hit = (state == BUSY) && (cnt == TO_LAST);
  assign stall_any   = |stall_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the combinational outputs to MEM/ctrl. Within BUSY the
  // priority is flush, then ack, then watchdog, so an ack landing on the
  // last allowed cycle still completes normally.
  always_comb begin
    state_nxt  = state;
    stallreq_o = 1'b0;
    cpu_data_o = 32'h0;
    unique case (state)
      IDLE: begin
        stallreq_o = cpu_ce_i & ~flush_i;
        if (cpu_ce_i && !flush_i) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        stallreq_o = ~wb_ack_i & ~flush_i & ~timeout_hit;
        if (wb_ack_i && !flush_i && is_load) begin
          cpu_data_o = wb_dat_i;
        end
        if (flush_i) begin
          state_nxt = IDLE;
        end else if (wb_ack_i || timeout_hit) begin
          state_nxt = stall_any ? WAIT_STALL : IDLE;
        end
      end
      WAIT_STALL: begin
        cpu_data_o = rd_buf;
        if (flush_i || !stall_any) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bus registers, read buffer, watchdog counter and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_adr_o  <= 32'h0;
      wb_dat_o  <= 32'h0;
      wb_sel_o  <= 4'h0;
      wb_we_o   <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
      rd_buf    <= 32'h0;
      cnt       <= 8'h0;
      bus_err_o <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            wb_adr_o <= cpu_addr_i;
            wb_dat_o <= cpu_data_i;
            wb_sel_o <= cpu_sel_i;
            wb_we_o  <= cpu_we_i;
            wb_stb_o <= 1'b1;
            wb_cyc_o <= 1'b1;
            cnt      <= 8'h0;
          end
        end
        BUSY: begin
          if (flush_i) begin
            wb_adr_o <= 32'h0;
            wb_dat_o <= 32'h0;
            wb_sel_o <= 4'h0;
            wb_we_o  <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            rd_buf   <= 32'h0;
          end else if (wb_ack_i) begin
            wb_adr_o <= 32'h0;
            wb_dat_o <= 32'h0;
            wb_sel_o <= 4'h0;
            wb_we_o  <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            // Stores leave a zero here so a stalled store returns 0.
            rd_buf   <= is_load ? wb_dat_i : 32'h0;
          end else if (timeout_hit) begin
            wb_adr_o  <= 32'h0;
            wb_dat_o  <= 32'h0;
            wb_sel_o  <= 4'h0;
            wb_we_o   <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_cyc_o  <= 1'b0;
            rd_buf    <= 32'h0;
            bus_err_o <= 1'b1;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        WAIT_STALL: begin
          if (flush_i) begin
            rd_buf <= 32'h0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_wishbone_if.sv
// Scoreboard bench for dbus_wishbone_if. The driver issues MEM requests and
// plays the slave; for every request it pushes the expected bus cycle and
// response (derived from the access rules) into a queue. A monitor on the
// falling edge pops a record whenever a new strobe appears and checks the
// whole cycle, the completion response and the stall-hold window.
module tb_dbus_wishbone_if;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_i;
  logic [31:0] cpu_data_o;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        stallreq_o;
  logic        bus_err_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  always #5 clk = ~clk;

  dbus_wishbone_if #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_data_i (cpu_data_i),
    .cpu_data_o (cpu_data_o),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .stallreq_o (stallreq_o),
    .bus_err_o  (bus_err_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .wb_we_o    (wb_we_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i)
  );

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    int          len;      // strobe cycles expected
    logic [31:0] data;     // data returned on completion / while held
    logic        err;      // watchdog abort expected
    logic        flushed;
  } rec_t;

  rec_t        q[$];
  rec_t        cur;
  int          total = 0;
  int          bad = 0;
  bit          mon_en = 1'b0;
  bit          mon_active = 1'b0;
  bit          post_pending = 1'b0;
  bit          post_err = 1'b0;
  bit          held = 1'b0;
  logic [31:0] held_data = 32'h0;
  int          idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, {31'h0, act}, {31'h0, exp});
  endtask

  task automatic stb_cycle_chk();
    bit term;
    term = (idx == cur.len - 1);
    chkb("cyc_eq_stb", wb_cyc_o, 1'b1);
    chk("adr", wb_adr_o, cur.adr);
    chk("dat", wb_dat_o, cur.dat);
    chk("sel", {28'h0, wb_sel_o}, {28'h0, cur.sel});
    chkb("we", wb_we_o, cur.we);
    chkb("busy_stallreq", stallreq_o, !term);
    chk("busy_data", cpu_data_o, term ? cur.data : 32'h0);
    chkb("busy_bus_err", bus_err_o, 1'b0);
    if (term) begin
      mon_active   = 1'b0;
      post_pending = 1'b1;
      post_err     = cur.err;
      held         = !cur.flushed && (stall_i != 6'h0);
      held_data    = cur.data;
    end
    idx++;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (mon_active) begin
        if (!wb_stb_o) begin
          chk("stb_len", idx, cur.len);
          mon_active = 1'b0;
        end else begin
          stb_cycle_chk();
        end
      end else begin
        bit was_post;
        was_post = post_pending;
        post_pending = 1'b0;
        chkb("bus_err", bus_err_o, was_post ? post_err : 1'b0);
        if (held) begin
          chk("hold_data", cpu_data_o, held_data);
          chkb("hold_stb", wb_stb_o, 1'b0);
          chkb("hold_stallreq", stallreq_o, 1'b0);
          held = (stall_i != 6'h0);
        end else if (wb_stb_o && !was_post) begin
          if (q.size() == 0) begin
            chkb("unexpected_stb", wb_stb_o, 1'b0);
          end else begin
            cur = q.pop_front();
            mon_active = 1'b1;
            idx = 0;
            stb_cycle_chk();
          end
        end else begin
          chkb("idle_stb", wb_stb_o, 1'b0);
          chkb("idle_cyc", wb_cyc_o, 1'b0);
          chkb("idle_stallreq", stallreq_o, cpu_ce_i & ~flush_i);
          chk("idle_data", cpu_data_o, 32'h0);
        end
      end
    end
  end

  // One MEM access. waits = BUSY cycles before ack (>= TO means never acked),
  // s = cycles the completion is held by stall_i, flush_at = BUSY cycle index
  // carrying a flush (-1 for none).
  task automatic do_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] wdat, input logic [31:0] rdat,
                        input int waits, input int s, input int flush_at);
    rec_t r;
    int   natural;
    natural = (waits < TO - 1) ? waits : TO - 1;
    r.adr = adr;
    r.dat = wdat;
    r.sel = sel;
    r.we  = we;
    if (flush_at >= 0 && flush_at <= natural) begin
      r.flushed = 1'b1;
      r.len     = flush_at + 1;
      r.err     = 1'b0;
      r.data    = 32'h0;
    end else begin
      r.flushed = 1'b0;
      r.len     = natural + 1;
      r.err     = (waits > TO - 1);
      r.data    = (!r.err && !we) ? rdat : 32'h0;
    end
    q.push_back(r);

    cpu_ce_i   = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = adr;
    cpu_sel_i  = sel;
    cpu_data_i = wdat;
    flush_i    = 1'b0;
    stall_i    = 6'h0;
    wb_ack_i   = 1'($urandom_range(0, 1));
    wb_dat_i   = $urandom;
    @(posedge clk); #1;
    for (int k = 0; k < r.len; k++) begin
      wb_ack_i = (k == waits);
      wb_dat_i = (k == waits) ? rdat : $urandom;
      flush_i  = (k == flush_at);
      stall_i  = (k == r.len - 1) ? ((s > 0) ? 6'b001111 : 6'h0) : 6'($urandom_range(0, 63));
      @(posedge clk); #1;
    end
    flush_i  = 1'b0;
    wb_ack_i = 1'($urandom_range(0, 1));
    wb_dat_i = $urandom;
    if (!r.flushed && s > 0) begin
      for (int j = 1; j < s; j++) begin
        stall_i = 6'($urandom_range(1, 63));
        @(posedge clk); #1;
        wb_ack_i = 1'($urandom_range(0, 1));
        wb_dat_i = $urandom;
      end
      stall_i = 6'h0;
      @(posedge clk); #1;
    end
    cpu_ce_i = 1'b0;
    stall_i  = 6'h0;
    wb_ack_i = 1'($urandom_range(0, 1));
    wb_dat_i = $urandom;
  endtask

  task automatic idle_cycle(input bit flushed_req);
    cpu_ce_i   = flushed_req;
    flush_i    = flushed_req ? 1'b1 : 1'($urandom_range(0, 1));
    cpu_addr_i = $urandom;
    stall_i    = 6'($urandom_range(0, 63));
    wb_ack_i   = 1'($urandom_range(0, 1));
    wb_dat_i   = $urandom;
    @(posedge clk); #1;
    cpu_ce_i = 1'b0;
    flush_i  = 1'b0;
    stall_i  = 6'h0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    cpu_ce_i   = 1'b0;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h0;
    cpu_sel_i  = 4'h0;
    cpu_data_i = 32'h0;
    stall_i    = 6'h0;
    flush_i    = 1'b0;
    wb_dat_i   = 32'h0;
    wb_ack_i   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chkb("rst_stb", wb_stb_o, 1'b0);
    chkb("rst_cyc", wb_cyc_o, 1'b0);
    chkb("rst_we", wb_we_o, 1'b0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_sel", {28'h0, wb_sel_o}, 32'h0);
    chkb("rst_stallreq", stallreq_o, 1'b0);
    chkb("rst_bus_err", bus_err_o, 1'b0);
    chk("rst_data", cpu_data_o, 32'h0);
    @(posedge clk); #1;
    rst    = 1'b0;
    mon_en = 1'b1;
    idle_cycle(1'b0);

    // Directed cases from the access rules.
    do_txn(1'b0, 32'h00000104, 4'b1111, 32'h0, 32'hDEADBEEF, 0, 0, -1);
    idle_cycle(1'b0);
    do_txn(1'b1, 32'h00000200, 4'b0011, 32'h12345678, 32'h87654321, 3, 0, -1);
    idle_cycle(1'b0);
    do_txn(1'b0, 32'h00000300, 4'b1111, 32'h0, 32'hA5A5A5A5, 0, 3, -1);
    idle_cycle(1'b0);
    do_txn(1'b0, 32'h00000400, 4'b1111, 32'h0, 32'h11112222, 1, 0, 1);
    idle_cycle(1'b0);
    do_txn(1'b0, 32'h00000500, 4'b1111, 32'h0, 32'h33334444, 10, 0, -1);
    idle_cycle(1'b0);
    do_txn(1'b0, 32'h00000504, 4'b1111, 32'h0, 32'h55556666, 10, 2, -1);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    do_txn(1'b1, 32'h00000600, 4'b1000, 32'hCAFEBABE, 32'h0, 0, 2, -1);

    for (int n = 0; n < 200; n++) begin
      int gap;
      int fa;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle(($urandom_range(0, 7) == 0));
      fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_txn(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)), $urandom, $urandom,
             int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), fa);
    end
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    mon_en = 1'b0;
    chk("queue_empty", q.size(), 32'h0);
    chkb("monitor_idle", mon_active, 1'b0);

    // Reset in the middle of a bus cycle; a late ack must be ignored.
    cpu_ce_i   = 1'b1;
    cpu_we_i   = 1'b0;
    cpu_addr_i = 32'h00000700;
    cpu_sel_i  = 4'hF;
    wb_ack_i   = 1'b0;
    flush_i    = 1'b0;
    stall_i    = 6'h0;
    @(posedge clk); #1;
    @(negedge clk);
    chkb("midrst_pre_stb", wb_stb_o, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    cpu_ce_i = 1'b0;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hCAFEF00D;
    @(negedge clk);
    chkb("midrst_stb", wb_stb_o, 1'b0);
    chkb("midrst_cyc", wb_cyc_o, 1'b0);
    chkb("midrst_we", wb_we_o, 1'b0);
    chk("midrst_adr", wb_adr_o, 32'h0);
    chk("midrst_dat", wb_dat_o, 32'h0);
    chk("midrst_sel", {28'h0, wb_sel_o}, 32'h0);
    chkb("midrst_stallreq", stallreq_o, 1'b0);
    chkb("midrst_bus_err", bus_err_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chkb("late_ack_stb", wb_stb_o, 1'b0);
      chk("late_ack_data", cpu_data_o, 32'h0);
      chkb("late_ack_stallreq", stallreq_o, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbus_wishbone_if.md
# dbus_wishbone_if

Data-side bus interface between the MEM stage and the external data memory. It turns the MEM stage's single-cycle RAM request (ce/we/sel/addr/data) into a classic Wishbone B3 master cycle. It holds the pipeline through `stallreq_o` until the slave acknowledges, and returns load data to the MEM stage. A watchdog aborts cycles that are never acknowledged.

## Interface
- `TIMEOUT`, default 255: maximum number of BUSY cycles without `wb_ack_i` before the cycle is aborted; range 1..255.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cpu_ce_i` in 1: MEM-stage request valid.
- `cpu_we_i` in 1: 1 = store, 0 = load.
- `cpu_addr_i` in 32: byte address.
- `cpu_sel_i` in 4: byte lanes; bit 3 = bits 31:24 (big-endian lane order).
- `cpu_data_i` in 32: store data.
- `cpu_data_o` out 32: load data to MEM stage.
- `stall_i` in 6: pipeline stall vector; bit 0 = PC … bit 5 = WB.
- `flush_i` in 1: exception flush from ctrl.
- `stallreq_o` out 1: stall request to ctrl.
- `bus_err_o` out 1: one-cycle pulse on timeout abort.
- `wb_adr_o` out 32, `wb_dat_o` out 32, `wb_sel_o` out 4, `wb_we_o` out 1, `wb_stb_o` out 1, `wb_cyc_o` out 1: Wishbone master outputs.
- `wb_dat_i` in 32, `wb_ack_i` in 1: Wishbone slave responses.

## Operation
- States: IDLE, BUSY, WAIT_STALL. All bus outputs are registered. `stallreq_o` and `cpu_data_o` are combinational from the state, inputs and `rd_buf`.
- IDLE
  - When `cpu_ce_i=1` and `flush_i=0`:
    - register `wb_adr_o`, `wb_dat_o`, `wb_sel_o` and `wb_we_o` from the cpu inputs;
    - set `wb_stb_o=wb_cyc_o=1`;
    - clear the timeout counter;
    - go to BUSY.
  - Otherwise stay in IDLE.
- BUSY
  - Priority 1, `flush_i=1`: drop stb/cyc/we, clear sel/adr/dat, clear `rd_buf`, go to IDLE.
  - Priority 2, `wb_ack_i=1`:
    - drop stb/cyc/we; adr/dat/sel are cleared to 0;
    - if the access is a load, `rd_buf<=wb_dat_i`;
    - go to WAIT_STALL if `stall_i!=0`, else go to IDLE.
  - Priority 3, counter reaches `TIMEOUT-1`:
    - drop stb/cyc;
    - `rd_buf<=0`;
    - pulse `bus_err_o` for one cycle;
    - go to WAIT_STALL if `stall_i!=0`, else go to IDLE.
  - Otherwise the counter increments by 1. The counter is 8 bits and saturates; it does not wrap.
- WAIT_STALL: when `stall_i==0` go to IDLE; a flush also returns to IDLE and clears `rd_buf`.
- `stallreq_o`:
  - IDLE: `cpu_ce_i & ~flush_i`.
  - BUSY: `~wb_ack_i & ~flush_i & ~timeout_hit`.
  - WAIT_STALL: 0.
- `cpu_data_o`:
  - BUSY with ack on a load: `wb_dat_i`.
  - WAIT_STALL: `rd_buf`.
  - Otherwise 0.
  - Store accesses always return 0.
- The stall vector only delays the return to IDLE. It never re-issues a bus cycle. The MEM request stays stable while stalled, so the held request is not replayed.

## Timing
- Reset values:
  - state IDLE;
  - all `wb_*` outputs 0;
  - `rd_buf` 0, counter 0, `bus_err_o` 0;
  - `stallreq_o` 0 and `cpu_data_o` 0 (combinational).
- Minimum latency: request seen in cycle N; `wb_stb_o` high in N+1. An ack in N+1 releases the stall in N+1 (combinationally) and presents `cpu_data_o` in the same cycle. Best case is a two-cycle access with one stall cycle.
- `wb_stb_o` and `wb_cyc_o` are always equal. They never stay high for the cycle after an ack.
- An ack arriving in IDLE or WAIT_STALL is ignored.
- Flush and ack in the same BUSY cycle: flush wins, and the data is discarded.
- Ack and timeout in the same cycle: ack wins, and there is no `bus_err_o`.
- `rst` asserted in any state forces the reset values on the next edge, including mid-cycle. stb/cyc drop without waiting for an ack.

## Test plan
- Load with 0-wait slave:
  - Stimulus: ce=1, we=0, addr=0x00000104, sel=1111; ack in first BUSY cycle with `wb_dat_i=0xDEADBEEF`.
  - Response: stb high exactly 1 cycle; `stallreq_o` high 1 cycle; `cpu_data_o=0xDEADBEEF` in the ack cycle.
- Store with 3-wait slave:
  - Stimulus: we=1, data=0x12345678, sel=0011.
  - Response: `wb_dat_o=0x12345678`, `wb_sel_o=0011` and `wb_we_o=1` held 4 cycles; `stallreq_o` high 4 cycles; `cpu_data_o=0`.
- Stall hold:
  - Stimulus: load acked with 0xA5A5A5A5 while `stall_i=6'b001111` for 3 further cycles.
  - Response: WAIT_STALL for 3 cycles with `cpu_data_o=0xA5A5A5A5`; no new stb; IDLE once stall_i=0.
- Flush:
  - Stimulus: `flush_i=1` in the 2nd BUSY cycle together with ack.
  - Response: stb/cyc 0 next cycle; `cpu_data_o=0`; state IDLE; `bus_err_o=0`.
- Timeout:
  - Stimulus: TIMEOUT=4, no ack.
  - Response: stb high 4 cycles; `bus_err_o` pulses 1 cycle; `stallreq_o` low from the timeout cycle; returned data 0.
- Reset mid-cycle:
  - Stimulus: rst=1 in BUSY.
  - Response: next edge gives all `wb_*`=0, IDLE, `stallreq_o=0`; a later ack is ignored.
